// File: rtl/car_sensor_conditioner_if.sv
// car_sensor_conditioner_if: detector-side and controller-side signals of the farm-road car sensor conditioner
interface car_sensor_conditioner_if #(parameter int CNT_W = 4);
  logic sensor_raw;
  logic farm_green;
  logic c;
  logic sensor_clean;
  logic sensor_fault;
  logic [CNT_W-1:0] car_count;
  modport master(output sensor_raw, farm_green, input c, car_count, sensor_clean, sensor_fault);
  modport slave(input sensor_raw, farm_green, output c, car_count, sensor_clean, sensor_fault);
endinterface

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: synchronizes and debounces the vehicle loop, queues arrivals, raises c for the controller
// Optional stuck-sensor fail-safe enabled by defining SENSOR_TIMEOUT_EN.
module car_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input logic clk,
  input logic reset,
  car_sensor_conditioner_if.slave bus
);
  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [CNT_W-1:0] count, count_n;
  logic sync_q1, sync_q2, clean, clean_q, c_q, arrival;
  assign clean = (state == HIGH) || (state == CHK_LOW);
  assign arrival = clean & ~clean_q;
  assign count_n = bus.farm_green ? '0 : (arrival && !(&count)) ? count + 1'b1 : count;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state <= LOW;
      cnt <= 8'd0;
      clean_q <= 1'b0;
      count <= '0;
      c_q <= 1'b0;
    end else begin
      sync_q1 <= bus.sensor_raw;
      sync_q2 <= sync_q1;
      state <= state_n;
      cnt <= cnt_n;
      clean_q <= clean;
      count <= count_n;
      c_q <= |count_n;
    end
  end
  // With a one-sample debounce the CHK states are bypassed entirely.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      LOW: if (sync_q2) begin
        state_n = (LAST == 8'd0) ? HIGH : CHK_HIGH;
        cnt_n = (LAST == 8'd0) ? 8'd0 : 8'd1;
      end
      CHK_HIGH: if (!sync_q2) begin
        state_n = LOW;
        cnt_n = 8'd0;
      end else if (cnt == LAST) begin
        state_n = HIGH;
        cnt_n = 8'd0;
      end else cnt_n = cnt + 8'd1;
      HIGH: if (!sync_q2) begin
        state_n = (LAST == 8'd0) ? LOW : CHK_LOW;
        cnt_n = (LAST == 8'd0) ? 8'd0 : 8'd1;
      end
      CHK_LOW: if (sync_q2) begin
        state_n = HIGH;
        cnt_n = 8'd0;
      end else if (cnt == LAST) begin
        state_n = LOW;
        cnt_n = 8'd0;
      end else cnt_n = cnt + 8'd1;
    endcase
  end
  assign bus.sensor_clean = clean;
  assign bus.car_count = count;
`ifdef SENSOR_TIMEOUT_EN
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  logic [15:0] stuck;
  logic fault;
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck <= 16'd0;
      fault <= 1'b0;
    end else begin
      stuck <= !clean ? 16'd0 : (stuck == TO) ? stuck : stuck + 16'd1;
      fault <= fault | (clean && (stuck == TO - 16'd1));
    end
  end
  assign bus.sensor_fault = fault;
  assign bus.c = c_q | (fault & ~bus.farm_green);
`else
  assign bus.sensor_fault = 1'b0;
  assign bus.c = c_q;
`endif
endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb_car_sensor_conditioner: directed and random stimulus against a window-based reference of the conditioner
module tb_car_sensor_conditioner;
  localparam int D = 4;
  localparam int MAXC = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_d1, m_d2, m_clean, m_cq;
  int m_cnt;
  bit win[$];
  car_sensor_conditioner_if #(.CNT_W(4)) bus();
  car_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Reference: clean flips once the last D synchronized samples all disagree with it.
  task automatic step(input bit raw, input bit fg, input bit rst);
    bit arr, all;
    bus.sensor_raw = raw;
    bus.farm_green = fg;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_clean = 0; m_cq = 0; m_cnt = 0;
      win.delete();
    end else begin
      arr = m_clean & ~m_cq;
      m_cq = m_clean;
      win.push_back(m_d2);
      if (win.size() > D) void'(win.pop_front());
      m_d2 = m_d1;
      m_d1 = raw;
      all = (win.size() == D);
      foreach (win[i]) if (win[i] == m_clean) all = 0;
      if (all) m_clean = ~m_clean;
      m_cnt = fg ? 0 : arr ? ((m_cnt == MAXC) ? MAXC : m_cnt + 1) : m_cnt;
    end
    #1;
    chk("sensor_clean", 32'(bus.sensor_clean), 32'(m_clean));
    chk("car_count", 32'(bus.car_count), 32'(m_cnt));
    chk("c", 32'(bus.c), 32'(m_cnt != 0));
    chk("sensor_fault", 32'(bus.sensor_fault), 32'd0);
  endtask
  task automatic pulses(input int n, input bit fg);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 8; i++) step(1, fg, 0);
      for (int i = 0; i < 8; i++) step(0, fg, 0);
    end
  endtask
  initial begin
    int run, lvl;
    bit found;
    bus.sensor_raw = 1'b1;
    bus.farm_green = 1'b0;
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    for (int i = 0; i <= D + 2; i++) begin
      step(1, 0, 0);
      if (i == D) chk("lat_clean_pre", 32'(bus.sensor_clean), 32'd0);
      if (i == D + 1) chk("lat_clean", 32'(bus.sensor_clean), 32'd1);
      if (i == D + 1) chk("lat_count_pre", 32'(bus.car_count), 32'd0);
      if (i == D + 2) chk("lat_count", 32'(bus.car_count), 32'd1);
      if (i == D + 2) chk("lat_c", 32'(bus.c), 32'd1);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("fall_no_effect", 32'(bus.car_count), 32'd1);
    step(0, 1, 0);
    chk("serve_clear", 32'(bus.car_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("glitch_clean", 32'(bus.sensor_clean), 32'd0);
    chk("glitch_c", 32'(bus.c), 32'd0);
    pulses(17, 0);
    chk("saturate", 32'(bus.car_count), 32'd15);
    step(0, 1, 0);
    pulses(3, 0);
    chk("queue3", 32'(bus.car_count), 32'd3);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0);
      found = m_clean & ~m_cq;
    end
    chk("arrival_wait", 32'(found), 32'd1);
    step(1, 1, 0);
    chk("collide_count", 32'(bus.car_count), 32'd0);
    chk("collide_c", 32'(bus.c), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    pulses(2, 1);
    chk("green_hold", 32'(bus.car_count), 32'd0);
    pulses(2, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("midreset_count", 32'(bus.car_count), 32'd0);
    chk("midreset_clean", 32'(bus.sensor_clean), 32'd0);
    run = 0;
    lvl = 0;
    for (int n = 0; n < 4000; n++) begin
      if (run == 0) begin
        lvl = int'($urandom_range(0, 1));
        run = int'($urandom_range(1, 10));
      end
      run--;
      step(lvl[0], $urandom_range(0, 24) == 0, $urandom_range(0, 599) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
